// File: rtl/exe_div_pkg.sv
// Shared constants and FSM state type for the EXE-stage iterative divider.
package exe_div_pkg;

  localparam int DIV_W    = 32;
  localparam int DIV_ITER = DIV_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/exe_div_step.sv
// One restoring radix-2 division step: shift {rem,quo} left, trial-subtract the divisor.
module exe_div_step #(
  parameter int W = 32
) (
  input  logic [W:0]   rem_in,
  input  logic [W-1:0] quo_in,
  input  logic [W-1:0] dvs,
  output logic [W:0]   rem_out,
  output logic [W-1:0] quo_out
);

  logic [W:0] rem_sh;
  logic [W:0] dvs_ext;
  logic       ge;

  always_comb begin
    rem_sh  = {rem_in[W-1:0], quo_in[W-1]};
    dvs_ext = {1'b0, dvs};
    ge      = (rem_sh >= dvs_ext);
    rem_out = ge ? (rem_sh - dvs_ext) : rem_sh;
    quo_out = {quo_in[W-2:0], ge};
  end

endmodule

// File: rtl/exe_div_unit.sv
// Multi-cycle signed/unsigned divider for the EXE stage; stalls the pipe while busy
// and presents sign-corrected quotient/remainder with a one-cycle done pulse.
module exe_div_unit #(
  parameter int DIV_W = exe_div_pkg::DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_sign,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  input  logic             cancel,
  output logic             stall_req,
  output logic             done,
  output logic [DIV_W-1:0] quotient,
  output logic [DIV_W-1:0] remainder
);

  import exe_div_pkg::*;

  localparam int CNT_W = $clog2(DIV_W + 1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DIV_W:0]   rem_q, rem_d;
  logic [DIV_W-1:0] quo_q, quo_d;
  logic [DIV_W-1:0] dvs_q, dvs_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic             is_sign_q, is_sign_d;
  logic [DIV_W-1:0] quotient_q, quotient_d;
  logic [DIV_W-1:0] remainder_q, remainder_d;

  logic [DIV_W:0]   step_rem;
  logic [DIV_W-1:0] step_quo;
  logic [DIV_W-1:0] mag_a;
  logic [DIV_W-1:0] mag_b;
  logic             neg_q;
  logic             neg_r;

  exe_div_step #(.W(DIV_W)) u_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .dvs     (dvs_q),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  always_comb begin
    mag_a = (is_sign && dividend[DIV_W-1]) ? (DIV_W'(0) - dividend) : dividend;
    mag_b = (is_sign && divisor[DIV_W-1])  ? (DIV_W'(0) - divisor)  : divisor;
    neg_q = is_sign_q && (sign_a_q ^ sign_b_q);
    neg_r = is_sign_q && sign_a_q;
  end

  // A flush also suppresses a done that would otherwise show in the same cycle.
  always_comb begin
    stall_req = ((state_q == IDLE) && start && !cancel) || (state_q == CALC);
    done      = (state_q == DONE) && !cancel;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    sign_a_d    = sign_a_q;
    sign_b_d    = sign_b_q;
    is_sign_d   = is_sign_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;

    if (cancel) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              state_d     = DONE;
              quotient_d  = '1;
              remainder_d = dividend;
            end else begin
              state_d   = CALC;
              cnt_d     = CNT_W'(DIV_W);
              rem_d     = '0;
              quo_d     = mag_a;
              dvs_d     = mag_b;
              sign_a_d  = dividend[DIV_W-1];
              sign_b_d  = divisor[DIV_W-1];
              is_sign_d = is_sign;
            end
          end
        end
        CALC: begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q - CNT_W'(1);
          // The step finishing on this edge is the last one, so publish its result now.
          if (cnt_q == CNT_W'(1)) begin
            state_d     = DONE;
            quotient_d  = neg_q ? (DIV_W'(0) - step_quo) : step_quo;
            remainder_d = neg_r ? (DIV_W'(0) - step_rem[DIV_W-1:0]) : step_rem[DIV_W-1:0];
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      is_sign_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      sign_a_q    <= sign_a_d;
      sign_b_q    <= sign_b_d;
      is_sign_q   <= is_sign_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;

endmodule

// File: tb/tb_exe_div_unit.sv
// Self-checking bench for exe_div_unit: directed corner cases plus randomized divides
// compared against an arithmetic reference model.
module tb_exe_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        is_sign;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        cancel;
  logic        stall_req;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int n_checks;
  int n_errors;

  exe_div_unit #(.DIV_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_sign   (is_sign),
    .dividend  (dividend),
    .divisor   (divisor),
    .cancel    (cancel),
    .stall_req (stall_req),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division, truncating toward zero.
  function automatic void ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    longint sa, sb, tq, tr;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!sgn) begin
      q = a / b;
      r = a % b;
    end else begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      tq = sa / sb;
      tr = sa % sb;
      q  = tq[31:0];
      r  = tr[31:0];
    end
  endfunction

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 6))
      0:       v = 32'd0;
      1:       v = 32'hFFFF_FFFF;
      2:       v = 32'h8000_0000;
      3:       v = 32'h7FFF_FFFF;
      4:       v = $urandom_range(1, 15);
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // driver + scoreboard for one complete divide
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] exp_q[$];
    logic [31:0] eq, er;
    int          lat, stall_cnt, exp_lat;
    bit          seen;
    ref_div(sgn, a, b, eq, er);
    exp_q.push_back(eq);
    exp_q.push_back(er);
    exp_lat = (b == 32'd0) ? 1 : 33;
    @(posedge clk); #1;
    start = 1'b1; is_sign = sgn; dividend = a; divisor = b; cancel = 1'b0;
    @(negedge clk);
    stall_cnt = int'(stall_req);
    lat  = 0;
    seen = 1'b0;
    for (int c = 1; c <= 60 && !seen; c++) begin
      @(posedge clk); #1;
      start    = 1'b0;
      dividend = $urandom;
      divisor  = $urandom;
      is_sign  = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        lat  = c;
        chk({tag, " stall_at_done"}, 32'(stall_req), 32'd0);
        chk({tag, " quotient"}, quotient, exp_q[0]);
        chk({tag, " remainder"}, remainder, exp_q[1]);
      end else begin
        stall_cnt += int'(stall_req);
      end
    end
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " stall_cycles"}, 32'(stall_cnt), 32'(exp_lat));
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, " done_one_cycle"}, 32'(done), 32'd0);
    chk({tag, " quotient_hold"}, quotient, exp_q[0]);
  endtask

  initial begin
    logic [31:0] prev_q, prev_r;
    bit          seen;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1; start = 1'b0; is_sign = 1'b0; dividend = '0; divisor = '0; cancel = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset quotient", quotient, 32'd0);
    chk("reset remainder", remainder, 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset stall", 32'(stall_req), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_div(1'b0, 32'd100, 32'd7, "u100_7");
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, "s-7_2");
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "s_min_m1");
    run_div(1'b0, 32'd5, 32'd0, "u5_0");
    run_div(1'b1, 32'hFFFF_FFFB, 32'd0, "s-5_0");
    run_div(1'b1, 32'd7, 32'hFFFF_FFFE, "s7_-2");

    // cancel mid-CALC: no done, stall drops, outputs keep previous DONE values
    prev_q = quotient;
    prev_r = remainder;
    @(posedge clk); #1;
    start = 1'b1; is_sign = 1'b0; dividend = 32'd1000; divisor = 32'd10;
    seen = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (c == 10) cancel = 1'b1;
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    @(posedge clk); #1;
    cancel = 1'b0;
    @(negedge clk);
    if (done) seen = 1'b1;
    chk("cancel stall_c11", 32'(stall_req), 32'd0);
    chk("cancel no_done", 32'(seen), 32'd0);
    chk("cancel quotient_hold", quotient, prev_q);
    chk("cancel remainder_hold", remainder, prev_r);
    run_div(1'b0, 32'd9, 32'd3, "u9_3_after_cancel");

    // start together with cancel in IDLE is discarded
    @(posedge clk); #1;
    start = 1'b1; cancel = 1'b1; dividend = 32'd50; divisor = 32'd5;
    @(negedge clk);
    chk("start_cancel stall", 32'(stall_req), 32'd0);
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
    @(negedge clk);
    chk("start_cancel stall_next", 32'(stall_req), 32'd0);
    chk("start_cancel done", 32'(done), 32'd0);

    // asynchronous reset mid-CALC
    @(posedge clk); #1;
    start = 1'b1; is_sign = 1'b0; dividend = 32'd12345; divisor = 32'd11;
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    rst = 1'b1;
    #1;
    chk("midrst quotient", quotient, 32'd0);
    chk("midrst remainder", remainder, 32'd0);
    chk("midrst stall", 32'(stall_req), 32'd0);
    chk("midrst done", 32'(done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_div(1'b0, 32'd20, 32'd6, "u20_6_after_rst");

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      logic        s;
      a = pick_operand();
      b = pick_operand();
      s = 1'($urandom_range(0, 1));
      run_div(s, a, b, $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
